// File: rtl/relay_frame_tx.sv
// Relay link transmitter: queues payload nibbles and sends gap, start nibble,
// payload, byte-alignment pad and end zeros MSB-first at one bit per BIT_CLKS clocks.
//
// state | meaning
// IDLE  | line low, waiting for a queued nibble
// GAP   | GAP_NIBBLES zero nibbles so the receiver can resynchronise
// START | 0xC (reader) or 0xF (tag)
// DATA  | one FIFO entry per nibble, 0x0 with an underrun pulse when empty
// PAD   | one zero nibble so the payload is a whole number of bytes
// END   | 4 (reader) or 2 (tag) zero nibbles
module relay_frame_tx #(
    parameter int BIT_CLKS    = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int GAP_NIBBLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fake_reader,
    input  logic [3:0] nib_in,
    input  logic       nib_last,
    input  logic       nib_valid,
    output logic       nib_ready,
    output logic       relay_out,
    output logic       busy,
    output logic       underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GAP   = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] PAD   = 3'd4;
    localparam logic [2:0] END   = 3'd5;

    logic [4:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [4:0]    head;

    logic [2:0]    state;
    logic [BW-1:0] bit_cnt;
    logic [1:0]    bit_idx;
    logic [3:0]    shreg;
    logic [3:0]    nib_cnt;
    logic          mode;
    logic          parity;
    logic          data_last;
    logic          bit_end;
    logic          nib_end;
    logic          data_due;
    logic [3:0]    end_last;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign nib_ready = ~full;
    assign push      = nib_valid & ~full;
    assign head      = fifo_mem[rd_ptr];

    assign bit_end   = (bit_cnt == BW'(BIT_CLKS - 1));
    assign nib_end   = (state != IDLE) && bit_end && (bit_idx == 2'd3);
    assign data_due  = nib_end && ((state == START) || ((state == DATA) && !data_last));
    assign pop       = data_due && !empty;
    assign end_last  = mode ? 4'd3 : 4'd1;

    assign relay_out = shreg[3];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {nib_last, nib_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= 2'd0;
            shreg     <= 4'h0;
            nib_cnt   <= 4'd0;
            mode      <= 1'b0;
            parity    <= 1'b0;
            data_last <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= '0;
                bit_idx <= 2'd0;
                shreg   <= 4'h0;
                if (!empty) begin
                    state   <= GAP;
                    mode    <= fake_reader;
                    nib_cnt <= 4'd0;
                end
            end else begin
                bit_cnt <= bit_end ? '0 : bit_cnt + BW'(1);
                if (bit_end) begin
                    bit_idx <= bit_idx + 2'd1;
                    shreg   <= {shreg[2:0], 1'b0};
                end
                if (nib_end) begin
                    nib_cnt <= nib_cnt + 4'd1;
                    shreg   <= 4'h0;
                    case (state)
                        GAP: begin
                            if (nib_cnt == 4'(GAP_NIBBLES - 1)) begin
                                state <= START;
                                shreg <= mode ? 4'hC : 4'hF;
                            end
                        end
                        START, DATA: begin
                            if (data_due) begin
                                state  <= DATA;
                                parity <= (state == START) ? 1'b1 : ~parity;
                                if (!empty) begin
                                    shreg     <= head[3:0];
                                    data_last <= head[4];
                                end else begin
                                    underrun  <= 1'b1;
                                    data_last <= 1'b0;
                                end
                            end else begin
                                // odd nibble count means half a byte is outstanding
                                state   <= parity ? PAD : END;
                                nib_cnt <= 4'd0;
                            end
                        end
                        PAD: begin
                            state   <= END;
                            nib_cnt <= 4'd0;
                        end
                        END: begin
                            if (nib_cnt == end_last) begin
                                nib_cnt <= 4'd0;
                                if (!empty) begin
                                    state <= GAP;
                                    mode  <= fake_reader;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
